// File: rtl/vga_frame_painter.sv
// rtl/vga_frame_painter.sv - per-frame background, score digit and cursor painter for the VGA adapter
// Candidates issue one per cycle; ROM data is re-joined with its x/y after ROM_LAT stages.
module vga_frame_painter #(
  parameter int SCR_W     = 320,
  parameter int SCR_H     = 240,
  parameter int XW        = 9,
  parameter int YW        = 8,
  parameter int CW        = 3,
  parameter int NDIG      = 4,
  parameter int SCORE_W   = 14,
  parameter int SPR_W     = 17,
  parameter int SPR_H     = 18,
  parameter int DIG_X0    = 120,
  parameter int DIG_Y0    = 155,
  parameter int CUR       = 4,
  parameter int CUR_COLOR = 0,
  parameter int KEY       = 7,
  parameter int ROM_LAT   = 1,
  parameter int BAW       = 17,
  parameter int GAW       = 12
) (
  input  logic               clk,
  input  logic               iReset,
  input  logic               V_SYNC,
  input  logic [1:0]         iScreen,
  input  logic               iShowScore,
  input  logic [SCORE_W-1:0] iScore,
  input  logic [XW-1:0]      iMouseX,
  input  logic [YW-1:0]      iMouseY,
  output logic [1:0]         oScreen,
  output logic [BAW-1:0]     oBgAddr,
  input  logic [CW-1:0]      iBgData,
  output logic [GAW-1:0]     oGlyphAddr,
  input  logic [CW-1:0]      iGlyphData,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic [CW-1:0]      color,
  output logic               writeEn,
  output logic               oBusy,
  output logic               oFrameDone,
  output logic               oOverrun
);

  typedef enum logic [2:0] {S_IDLE, S_BCD, S_BG, S_DIG, S_CUR, S_DRAIN} state_t;

  localparam logic [1:0] TAG_BG  = 2'd0;
  localparam logic [1:0] TAG_GLY = 2'd1;
  localparam logic [1:0] TAG_CUR = 2'd2;
  localparam int BCDW = 4 * NDIG;
  localparam int L    = ROM_LAT - 1;

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) r = r * 32'd10;
    return r;
  endfunction

  localparam logic [31:0]         POW10   = pow10(NDIG);
  localparam logic [BCDW-1:0]     NINES   = {NDIG{4'd9}};
  localparam logic signed [XW:0]  X_LAST  = (XW+1)'(SCR_W - 1);
  localparam logic signed [YW:0]  Y_LAST  = (YW+1)'(SCR_H - 1);
  localparam logic signed [XW:0]  DX0     = (XW+1)'(DIG_X0);
  localparam logic signed [YW:0]  DY0     = (YW+1)'(DIG_Y0);
  localparam logic signed [XW:0]  SPR_WX  = (XW+1)'(SPR_W);
  localparam logic signed [XW:0]  HALF_X  = (XW+1)'(CUR / 2);
  localparam logic signed [YW:0]  HALF_Y  = (YW+1)'(CUR / 2);
  localparam logic [GAW-1:0]      GLYPH_N = GAW'(SPR_W * SPR_H);
  localparam logic [CW-1:0]       CURC    = CW'(CUR_COLOR);
  localparam logic [CW-1:0]       KEYC    = CW'(KEY);
  localparam logic [15:0]         SC_LAST = 16'(SCORE_W - 1);
  localparam logic [15:0]         GC_LAST = 16'(SPR_W - 1);
  localparam logic [15:0]         GR_LAST = 16'(SPR_H - 1);
  localparam logic [15:0]         DD_LAST = 16'(NDIG - 1);
  localparam logic [15:0]         CU_LAST = 16'(CUR - 1);
  localparam logic [15:0]         DR_LAST = 16'(ROM_LAT - 1);

  // One double-dabble step: adjust every BCD digit, then shift the binary MSB in.
  function automatic logic [BCDW+SCORE_W-1:0] dd_step(input logic [BCDW-1:0] b,
                                                       input logic [SCORE_W-1:0] s);
    logic [BCDW-1:0] a;
    logic [BCDW+SCORE_W-1:0] t;
    a = b;
    for (int i = 0; i < NDIG; i++)
      if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    t = {a, s};
    return t << 1;
  endfunction

  // Digit d counts from the most significant end.
  function automatic logic [3:0] dig_of(input logic [BCDW-1:0] b, input logic [15:0] d);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < NDIG; i++)
      if (16'(i) == d) r = b[4*(NDIG-1-i) +: 4];
    return r;
  endfunction

  function automatic logic [GAW-1:0] glyph_base(input logic [3:0] v);
    return GAW'(v) * GLYPH_N;
  endfunction

  state_t                state;
  logic                  vs_q;
  logic                  fall;
  logic                  show_q;
  logic                  ovf_q;
  logic [BCDW-1:0]       bcd;
  logic [SCORE_W-1:0]    bin;
  logic signed [XW:0]    px;
  logic signed [XW:0]    cx0;
  logic signed [XW:0]    digx;
  logic signed [YW:0]    py;
  logic signed [YW:0]    cy0;
  logic [15:0]           bcnt;
  logic [15:0]           gc;
  logic [15:0]           gr;
  logic [15:0]           dd;
  logic [15:0]           cc;
  logic [15:0]           cr;
  logic [15:0]           dcnt;

  logic                  p_v [ROM_LAT];
  logic [XW-1:0]         p_x [ROM_LAT];
  logic [YW-1:0]         p_y [ROM_LAT];
  logic [1:0]            p_t [ROM_LAT];
  logic                  p_c [ROM_LAT];

  logic                  iss_v;
  logic                  iss_c;
  logic [1:0]            iss_t;

  assign fall = vs_q & ~V_SYNC;

  always_comb begin
    iss_v = 1'b0;
    iss_t = TAG_BG;
    iss_c = 1'b0;
    case (state)
      S_BG:  iss_v = 1'b1;
      S_DIG: begin
        iss_v = 1'b1;
        iss_t = TAG_GLY;
      end
      S_CUR: begin
        iss_v = 1'b1;
        iss_t = TAG_CUR;
        iss_c = px[XW] | (px > X_LAST) | py[YW] | (py > Y_LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (iReset) begin
      state      <= S_IDLE;
      vs_q       <= 1'b0;
      show_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bcd        <= '0;
      bin        <= '0;
      px         <= '0;
      py         <= '0;
      cx0        <= '0;
      cy0        <= '0;
      digx       <= '0;
      bcnt       <= '0;
      gc         <= '0;
      gr         <= '0;
      dd         <= '0;
      cc         <= '0;
      cr         <= '0;
      dcnt       <= '0;
      oScreen    <= '0;
      oBgAddr    <= '0;
      oGlyphAddr <= '0;
      oBusy      <= 1'b0;
      oFrameDone <= 1'b0;
      oOverrun   <= 1'b0;
      for (int i = 0; i < ROM_LAT; i++) begin
        p_v[i] <= 1'b0;
        p_x[i] <= '0;
        p_y[i] <= '0;
        p_t[i] <= TAG_BG;
        p_c[i] <= 1'b0;
      end
    end else begin
      vs_q       <= V_SYNC;
      oFrameDone <= 1'b0;
      oOverrun   <= 1'b0;

      p_v[0] <= iss_v;
      p_x[0] <= px[XW-1:0];
      p_y[0] <= py[YW-1:0];
      p_t[0] <= iss_t;
      p_c[0] <= iss_c;
      for (int i = 1; i < ROM_LAT; i++) begin
        p_v[i] <= p_v[i-1];
        p_x[i] <= p_x[i-1];
        p_y[i] <= p_y[i-1];
        p_t[i] <= p_t[i-1];
        p_c[i] <= p_c[i-1];
      end

      if (fall) begin
        if (state == S_IDLE) begin
          state   <= S_BCD;
          oBusy   <= 1'b1;
          oScreen <= iScreen;
          show_q  <= iShowScore;
          ovf_q   <= (32'(iScore) >= POW10);
          bin     <= iScore;
          bcd     <= '0;
          bcnt    <= '0;
          cx0     <= $signed({1'b0, iMouseX}) - HALF_X;
          cy0     <= $signed({1'b0, iMouseY}) - HALF_Y;
        end else begin
          oOverrun <= 1'b1;
        end
      end

      case (state)
        S_BCD: begin
          {bcd, bin} <= dd_step(bcd, bin);
          bcnt       <= bcnt + 16'd1;
          if (bcnt == SC_LAST) begin
            if (ovf_q) bcd <= NINES;
            state   <= S_BG;
            px      <= '0;
            py      <= '0;
            oBgAddr <= '0;
          end
        end

        S_BG: begin
          oBgAddr <= oBgAddr + 1'b1;
          if (px == X_LAST) begin
            px <= '0;
            py <= py + 1'b1;
          end else begin
            px <= px + 1'b1;
          end
          if (px == X_LAST && py == Y_LAST) begin
            if (show_q) begin
              state      <= S_DIG;
              dd         <= '0;
              gc         <= '0;
              gr         <= '0;
              px         <= DX0;
              py         <= DY0;
              digx       <= DX0;
              oGlyphAddr <= glyph_base(dig_of(bcd, 16'd0));
            end else begin
              state <= S_CUR;
              px    <= cx0;
              py    <= cy0;
              cc    <= '0;
              cr    <= '0;
            end
          end
        end

        // Within one glyph the ROM address is simply sequential (row-major).
        S_DIG: begin
          oGlyphAddr <= oGlyphAddr + 1'b1;
          px         <= px + 1'b1;
          gc         <= gc + 16'd1;
          if (gc == GC_LAST) begin
            gc <= '0;
            px <= digx;
            py <= py + 1'b1;
            gr <= gr + 16'd1;
            if (gr == GR_LAST) begin
              gr         <= '0;
              py         <= DY0;
              dd         <= dd + 16'd1;
              digx       <= digx + SPR_WX;
              px         <= digx + SPR_WX;
              oGlyphAddr <= glyph_base(dig_of(bcd, dd + 16'd1));
              if (dd == DD_LAST) begin
                state <= S_CUR;
                px    <= cx0;
                py    <= cy0;
                cc    <= '0;
                cr    <= '0;
              end
            end
          end
        end

        S_CUR: begin
          px <= px + 1'b1;
          cc <= cc + 16'd1;
          if (cc == CU_LAST) begin
            cc <= '0;
            px <= cx0;
            py <= py + 1'b1;
            cr <= cr + 16'd1;
            if (cr == CU_LAST) begin
              state <= S_DRAIN;
              dcnt  <= '0;
            end
          end
        end

        S_DRAIN: begin
          dcnt <= dcnt + 16'd1;
          if (dcnt == DR_LAST) begin
            state      <= S_IDLE;
            oBusy      <= 1'b0;
            oFrameDone <= 1'b1;
          end
        end

        default: ;
      endcase
    end
  end

  assign x = p_x[L];
  assign y = p_y[L];

  always_comb begin
    color   = '0;
    writeEn = 1'b0;
    if (p_v[L]) begin
      case (p_t[L])
        TAG_BG:  color = iBgData;
        TAG_GLY: color = iGlyphData;
        default: color = CURC;
      endcase
      writeEn = ~p_c[L] & ~((p_t[L] == TAG_GLY) && (iGlyphData == KEYC));
    end
  end

endmodule

// File: tb/tb_vga_frame_painter.sv
// tb/tb_vga_frame_painter.sv - directed bench for vga_frame_painter at ROM_LAT 1 and 3
// Small screen geometry keeps each frame under a thousand cycles.
module tb_vga_frame_painter;

  localparam int SW = 32, SH = 24, SPW = 5, SPH = 6, DX = 8, DY = 10;
  localparam int GN = SPW * SPH;
  localparam int SCW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           iReset, V_SYNC, iShowScore;
  logic [1:0]     iScreen;
  logic [SCW-1:0] iScore;
  logic [5:0]     iMouseX;
  logic [4:0]     iMouseY;

  logic [1:0] s1, s3;
  logic [9:0] a1, a3;
  logic [8:0] ga1, ga3;
  logic [2:0] bg1, gl1, bg3a, bg3b, bg3c, gl3a, gl3b, gl3c;
  logic [5:0] x1, x3;
  logic [4:0] y1, y3;
  logic [2:0] c1, c3;
  logic       we1, we3, bz1, bz3, fd1, fd3, ov1, ov3;

  vga_frame_painter #(.SCR_W(SW), .SCR_H(SH), .XW(6), .YW(5), .CW(3), .NDIG(4), .SCORE_W(SCW),
    .SPR_W(SPW), .SPR_H(SPH), .DIG_X0(DX), .DIG_Y0(DY), .CUR(4), .CUR_COLOR(0), .KEY(7),
    .ROM_LAT(1), .BAW(10), .GAW(9)) dut (
    .clk(clk), .iReset(iReset), .V_SYNC(V_SYNC), .iScreen(iScreen), .iShowScore(iShowScore),
    .iScore(iScore), .iMouseX(iMouseX), .iMouseY(iMouseY), .oScreen(s1), .oBgAddr(a1),
    .iBgData(bg1), .oGlyphAddr(ga1), .iGlyphData(gl1), .x(x1), .y(y1), .color(c1),
    .writeEn(we1), .oBusy(bz1), .oFrameDone(fd1), .oOverrun(ov1));

  vga_frame_painter #(.SCR_W(SW), .SCR_H(SH), .XW(6), .YW(5), .CW(3), .NDIG(4), .SCORE_W(SCW),
    .SPR_W(SPW), .SPR_H(SPH), .DIG_X0(DX), .DIG_Y0(DY), .CUR(4), .CUR_COLOR(0), .KEY(7),
    .ROM_LAT(3), .BAW(10), .GAW(9)) dut3 (
    .clk(clk), .iReset(iReset), .V_SYNC(V_SYNC), .iScreen(iScreen), .iShowScore(iShowScore),
    .iScore(iScore), .iMouseX(iMouseX), .iMouseY(iMouseY), .oScreen(s3), .oBgAddr(a3),
    .iBgData(bg3c), .oGlyphAddr(ga3), .iGlyphData(gl3c), .x(x3), .y(y3), .color(c3),
    .writeEn(we3), .oBusy(bz3), .oFrameDone(fd3), .oOverrun(ov3));

  function automatic logic [2:0] bgfun(input int a, input int s);
    return 3'((a ^ (a >> 3)) + 3 * s);
  endfunction

  function automatic logic [2:0] gfun(input int a);
    return 3'(a * 5 + (a >> 3));
  endfunction

  function automatic int pack(input int xx, input int yy, input int cc);
    return (xx << 16) | (yy << 8) | cc;
  endfunction

  always @(posedge clk) begin
    bg1  <= bgfun(int'(a1), int'(s1));
    gl1  <= gfun(int'(ga1));
    bg3a <= bgfun(int'(a3), int'(s3));
    bg3b <= bg3a;
    bg3c <= bg3b;
    gl3a <= gfun(int'(ga3));
    gl3b <= gl3a;
    gl3c <= gl3b;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_pass = 0;
  int cap1[$], cap3[$], exp_q[$];
  bit cap_en = 1'b0;
  int first1, first3, done1, done3, dcyc1, dcyc3, ovr1, ovr3, edge_cyc;
  logic bad1, bad3;

  always @(negedge clk) begin
    if (cap_en && we1) begin
      cap1.push_back(pack(int'(x1), int'(y1), int'(c1)));
      if (first1 < 0) first1 = cyc;
    end
    if (cap_en && we3) begin
      cap3.push_back(pack(int'(x3), int'(y3), int'(c3)));
      if (first3 < 0) first3 = cyc;
    end
    if (fd1) begin done1++; dcyc1 = cyc; bad1 = bz1; end
    if (fd3) begin done3++; dcyc3 = cyc; bad3 = bz3; end
    if (ov1) ovr1++;
    if (ov3) ovr3++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic build_expect(input int scr, input bit show, input int score, input int mx, input int my);
    int dig[4];
    exp_q.delete();
    for (int yy = 0; yy < SH; yy++)
      for (int xx = 0; xx < SW; xx++)
        exp_q.push_back(pack(xx, yy, int'(bgfun(yy * SW + xx, scr))));
    if (show) begin
      if (score >= 10000) dig = '{9, 9, 9, 9};
      else dig = '{score / 1000 % 10, score / 100 % 10, score / 10 % 10, score % 10};
      for (int d = 0; d < 4; d++)
        for (int r = 0; r < SPH; r++)
          for (int c = 0; c < SPW; c++) begin
            logic [2:0] g;
            g = gfun(dig[d] * GN + r * SPW + c);
            if (g != 3'd7) exp_q.push_back(pack(DX + d * SPW + c, DY + r, int'(g)));
          end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        int xx, yy;
        xx = mx - 2 + c;
        yy = my - 2 + r;
        if (xx >= 0 && xx < SW && yy >= 0 && yy < SH) exp_q.push_back(pack(xx, yy, 0));
      end
  endtask

  task automatic cmp_stream(input string nm, input int cap[$]);
    int nmis, n;
    nmis = 0;
    n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
    check({nm, " write count"}, cap.size(), exp_q.size());
    for (int i = 0; i < n; i++)
      if (cap[i] != exp_q[i]) begin
        if (nmis == 0) $display("  %s first bad write #%0d got %h want %h", nm, i, cap[i], exp_q[i]);
        nmis++;
      end
    check({nm, " bad pixels"}, nmis, 0);
  endtask

  task automatic run_frame(input string nm, input int scr, input bit show, input int score,
                           input int mx, input int my, input bit do_ovr, input bit do_abort);
    int n_iss;
    @(negedge clk);
    iScreen = 2'(scr); iShowScore = show; iScore = SCW'(score);
    iMouseX = 6'(mx); iMouseY = 5'(my); V_SYNC = 1'b1;
    repeat (3) @(negedge clk);
    cap1.delete(); cap3.delete();
    first1 = -1; first3 = -1; done1 = 0; done3 = 0; ovr1 = 0; ovr3 = 0;
    bad1 = 1'b0; bad3 = 1'b0; cap_en = 1'b1;
    V_SYNC = 1'b0;
    edge_cyc = cyc;
    @(posedge clk); #1;
    check({nm, " busy@1"}, bz1, 1);
    check({nm, " busy@1 lat3"}, bz3, 1);
    check({nm, " oScreen"}, s1, scr);
    iScreen = 2'(scr + 1); iShowScore = !show; iScore = '0;
    iMouseX = 6'(mx + 13); iMouseY = 5'(my + 7);
    if (do_abort) begin
      repeat (200) @(posedge clk);
      @(negedge clk); iReset = 1'b1;
      @(posedge clk); #1;
      check({nm, " we after reset"}, we1, 0);
      check({nm, " busy after reset"}, bz1, 0);
      check({nm, " we after reset lat3"}, we3, 0);
      check({nm, " busy after reset lat3"}, bz3, 0);
      check({nm, " addr after reset"}, a1, 0);
      @(negedge clk); iReset = 1'b0;
      cap_en = 1'b0;
      return;
    end
    if (do_ovr) begin
      repeat (100) @(negedge clk);
      V_SYNC = 1'b1;
      repeat (2) @(negedge clk);
      V_SYNC = 1'b0;
    end
    for (int i = 0; i < 4000 && !(done1 > 0 && done3 > 0); i++) @(posedge clk);
    repeat (4) @(posedge clk);
    cap_en = 1'b0;
    n_iss = SW * SH + (show ? 4 * GN : 0) + 16;
    build_expect(scr, show, score, mx, my);
    check({nm, " done pulses"}, done1, 1);
    check({nm, " done pulses lat3"}, done3, 1);
    check({nm, " done time"}, dcyc1 - edge_cyc, SCW + n_iss + 1 + 1);
    check({nm, " done time lat3"}, dcyc3 - edge_cyc, SCW + n_iss + 3 + 1);
    check({nm, " busy at done"}, {bad1, bad3}, 0);
    check({nm, " first write time"}, first1 - edge_cyc, SCW + 1 + 1);
    check({nm, " first write time lat3"}, first3 - edge_cyc, SCW + 1 + 3);
    check({nm, " overrun pulses"}, ovr1, do_ovr ? 1 : 0);
    check({nm, " overrun pulses lat3"}, ovr3, do_ovr ? 1 : 0);
    cmp_stream({nm, " lat1"}, cap1);
    cmp_stream({nm, " lat3"}, cap3);
  endtask

  initial begin
    iReset = 1'b1; V_SYNC = 1'b1; iScreen = '0; iShowScore = 1'b0;
    iScore = '0; iMouseX = '0; iMouseY = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {x1, y1, c1, we1, s1, a1, ga1, bz1, fd1, ov1}, 0);
    check("reset outputs lat3", {x3, y3, c3, we3, s3, a3, ga3, bz3, fd3, ov3}, 0);
    @(negedge clk); iReset = 1'b0;

    run_frame("plain", 1, 0, 0, 10, 10, 0, 0);
    run_frame("score1234", 2, 1, 1234, 31, 23, 0, 0);
    run_frame("score12000", 0, 1, 12000, 0, 0, 0, 0);
    run_frame("overrun", 3, 1, 567, 5, 5, 1, 0);
    run_frame("abort", 1, 1, 4321, 7, 7, 0, 1);
    run_frame("after_reset", 1, 1, 9999, 16, 12, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
